// File: rtl/lutram_array.sv
// Two-read/one-write distributed-RAM array with a self-clearing sweep after reset or on request.
// Reads return CLEAR_VALUE while the sweep is running; READ_LATENCY selects async or registered reads.
module lutram_array #(
    parameter int unsigned                 DATA_WIDTH   = 16,
    parameter int unsigned                 ADDR_WIDTH   = 5,
    parameter int unsigned                 READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0]       CLEAR_VALUE  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  ready,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // The sweep owns the single write port; user writes only reach it in READY without clear.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = din;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = CLEAR_VALUE;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                end else if (we) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready = (state_q == ST_READY);

    if (READ_LATENCY == 0) begin : g_async_read
        always_comb begin
            dout_a = (state_q == ST_CLEAR) ? CLEAR_VALUE : mem[raddr_a];
            dout_b = (state_q == ST_CLEAR) ? CLEAR_VALUE : mem[raddr_b];
        end
    end else begin : g_sync_read
        logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;

        // Write-first: a same-cycle write to the read address bypasses the array.
        always_ff @(posedge clock) begin
            if (reset || state_q == ST_CLEAR) begin
                dout_a_q <= CLEAR_VALUE;
                dout_b_q <= CLEAR_VALUE;
            end else begin
                dout_a_q <= (mem_we && mem_waddr == raddr_a) ? mem_wdata : mem[raddr_a];
                dout_b_q <= (mem_we && mem_waddr == raddr_b) ? mem_wdata : mem[raddr_b];
            end
        end

        assign dout_a = dout_a_q;
        assign dout_b = dout_b_q;
    end

endmodule

// File: tb/tb_lutram_array.sv
// Scoreboard bench for lutram_array: async-read and registered-read instances sharing stimulus,
// plus a wide/deep variant with a non-zero clear value.
module tb_lutram_array;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus for the two default-geometry instances
    logic        reset = 1'b1, clear = 1'b0, we = 1'b0;
    logic [4:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [15:0] din = '0;
    logic        ready0, ready1;
    logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;

    // Variant instance
    logic        reset2 = 1'b1, clear2 = 1'b0, we2 = 1'b0;
    logic [5:0]  waddr2 = '0, raddr_a2 = '0, raddr_b2 = '0;
    logic [31:0] din2 = '0;
    logic        ready2;
    logic [31:0] dout_a2, dout_b2;

    lutram_array #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .clear(clear), .ready(ready0),
        .we(we), .waddr(waddr), .din(din),
        .raddr_a(raddr_a), .dout_a(dout_a0), .raddr_b(raddr_b), .dout_b(dout_b0)
    );

    lutram_array #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .clear(clear), .ready(ready1),
        .we(we), .waddr(waddr), .din(din),
        .raddr_a(raddr_a), .dout_a(dout_a1), .raddr_b(raddr_b), .dout_b(dout_b1)
    );

    lutram_array #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(0),
                   .CLEAR_VALUE(32'hDEADBEEF)) dut2 (
        .clock(clock), .reset(reset2), .clear(clear2), .ready(ready2),
        .we(we2), .waddr(waddr2), .din(din2),
        .raddr_a(raddr_a2), .dout_a(dout_a2), .raddr_b(raddr_b2), .dout_b(dout_b2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        q0[$];   // expectations for the async-read instance
    exp_t        q1[$];   // expectations for the registered-read instance
    logic [15:0] model [32];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; din = d;
        step();
        we = 1'b0;
        model[a] = d;
    endtask

    // Read every address on both ports; async results checked same cycle, registered one cycle later.
    task automatic test_read_all(input string tag);
        exp_t e;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) begin
                raddr_a = 5'(i);
                raddr_b = 5'(31 - i);
                q0.push_back('{model[i], model[31 - i]});
                q1.push_back('{model[i], model[31 - i]});
            end
            @(negedge clock);
            if (i < 32) begin
                e = q0.pop_front();
                vectors++;
                if (dout_a0 !== e.a || dout_b0 !== e.b) begin
                    miscompares++;
                    $display("FAIL %s lat0 addr %0d: got a=%h b=%h, want a=%h b=%h",
                             tag, i, dout_a0, dout_b0, e.a, e.b);
                end
            end
            if (i > 0) begin
                e = q1.pop_front();
                vectors++;
                if (dout_a1 !== e.a || dout_b1 !== e.b) begin
                    miscompares++;
                    $display("FAIL %s lat1 addr %0d: got a=%h b=%h, want a=%h b=%h",
                             tag, i - 1, dout_a1, dout_b1, e.a, e.b);
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clock);
        vectors++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0 || dout_a0 !== 16'h0 || dout_a1 !== 16'h0
            || dout_b1 !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b/%b a0=%h a1=%h b1=%h, want 0/0 0000 0000 0000",
                     ready0, ready1, dout_a0, dout_a1, dout_b1);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clock);
            vectors++;
            if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_ready_low cycle %0d: got %b/%b, want 0/0", c, ready0, ready1);
            end
            step();
        end
        @(negedge clock);
        vectors++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_ready_rise cycle 32: got %b/%b, want 1/1", ready0, ready1);
        end
        step();
        for (int i = 0; i < 32; i++) model[i] = 16'h0;
        test_read_all("sweep_zero");
    endtask

    task automatic test_basic_rw();
        exp_t e;
        do_write(5'd3, 16'hBEEF);
        do_write(5'd31, 16'h1234);
        raddr_a = 5'd3;
        raddr_b = 5'd31;
        q0.push_back('{model[3], model[31]});
        q1.push_back('{model[3], model[31]});
        @(negedge clock);
        e = q0.pop_front();
        vectors++;
        if (dout_a0 !== e.a || dout_b0 !== e.b) begin
            miscompares++;
            $display("FAIL basic_rw lat0: got a=%h b=%h, want a=%h b=%h", dout_a0, dout_b0, e.a, e.b);
        end
        step();
        @(negedge clock);
        e = q1.pop_front();
        vectors++;
        if (dout_a1 !== e.a || dout_b1 !== e.b) begin
            miscompares++;
            $display("FAIL basic_rw lat1: got a=%h b=%h, want a=%h b=%h", dout_a1, dout_b1, e.a, e.b);
        end
        step();
    endtask

    task automatic test_collision();
        exp_t e;
        // Address 7 holds zero from the sweep; write and read it in the same cycle.
        we = 1'b1; waddr = 5'd7; din = 16'hA5A5;
        raddr_a = 5'd7; raddr_b = 5'd3;
        q0.push_back('{model[7], model[3]});      // async: old contents before the edge
        q1.push_back('{16'hA5A5, model[3]});     // registered: write-first
        @(negedge clock);
        e = q0.pop_front();
        vectors++;
        if (dout_a0 !== e.a || dout_b0 !== e.b) begin
            miscompares++;
            $display("FAIL collision_pre lat0: got a=%h b=%h, want a=%h b=%h", dout_a0, dout_b0, e.a, e.b);
        end
        step();
        we = 1'b0;
        model[7] = 16'hA5A5;
        q0.push_back('{model[7], model[3]});
        @(negedge clock);
        e = q0.pop_front();
        vectors++;
        if (dout_a0 !== e.a || dout_b0 !== e.b) begin
            miscompares++;
            $display("FAIL collision_post lat0: got a=%h b=%h, want a=%h b=%h", dout_a0, dout_b0, e.a, e.b);
        end
        e = q1.pop_front();
        vectors++;
        if (dout_a1 !== e.a || dout_b1 !== e.b) begin
            miscompares++;
            $display("FAIL collision lat1: got a=%h b=%h, want a=%h b=%h", dout_a1, dout_b1, e.a, e.b);
        end
        step();
    endtask

    task automatic test_clear_with_write();
        clear = 1'b1; we = 1'b1; waddr = 5'd5; din = 16'hFFFF;
        step();
        clear = 1'b0;
        // Keep hammering writes during the sweep; a second clear mid-sweep must not restart it.
        for (int c = 0; c < 32; c++) begin
            if (c == 10) clear = 1'b1;
            if (c == 11) clear = 1'b0;
            waddr = 5'(c);
            @(negedge clock);
            vectors++;
            if (ready0 !== 1'b0 || ready1 !== 1'b0 || dout_a0 !== 16'h0) begin
                miscompares++;
                $display("FAIL clear_sweep cycle %0d: got rdy=%b/%b a0=%h, want 0/0 0000",
                         c, ready0, ready1, dout_a0);
            end
            step();
        end
        we = 1'b0;
        @(negedge clock);
        vectors++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_ready_rise: got %b/%b, want 1/1", ready0, ready1);
        end
        step();
        for (int i = 0; i < 32; i++) model[i] = 16'h0;
        test_read_all("clear_zero");
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        do_write(5'd9, 16'h5555);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        repeat (2) step();
        @(negedge clock);
        vectors++;
        if (ready0 !== 1'b0 || dout_a0 !== 16'h0 || dout_b1 !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got rdy=%b a0=%h b1=%h, want 0 0000 0000", ready0, dout_a0, dout_b1);
        end
        step();
        reset = 1'b0;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clock);
            if (ready0 === 1'b1) break;
            step();
            cnt++;
        end
        vectors++;
        if (cnt !== 32) begin
            miscompares++;
            $display("FAIL reset_mid_sweep: ready after %0d cycles, want 32", cnt);
        end
        step();
        for (int i = 0; i < 32; i++) model[i] = 16'h0;
        test_read_all("remid_zero");
    endtask

    task automatic test_variant();
        int cnt;
        reset2 = 1'b1;
        repeat (2) step();
        reset2 = 1'b0;
        cnt = 0;
        while (cnt < 300) begin
            @(negedge clock);
            if (ready2 === 1'b1) break;
            step();
            cnt++;
        end
        vectors++;
        if (cnt !== 64) begin
            miscompares++;
            $display("FAIL variant_sweep: ready after %0d cycles, want 64", cnt);
        end
        step();
        for (int i = 0; i < 64; i++) begin
            raddr_a2 = 6'(i);
            raddr_b2 = 6'(63 - i);
            @(negedge clock);
            vectors++;
            if (dout_a2 !== 32'hDEADBEEF || dout_b2 !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL variant_read addr %0d: got a=%h b=%h, want deadbeef", i, dout_a2, dout_b2);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_collision();
        test_clear_with_write();
        test_reset_mid_sweep();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
